// File: rtl/rx_host.sv
// Host end of the remote-IO sdio link: one frame every PERIOD clocks. Each frame
// sends a 4-bit address and a 16-bit write word, then captures 24 ADC bytes and a readback word.
module rx_host #(
    parameter int unsigned PERIOD    = 128,
    parameter int unsigned RX_OFFSET = 16,
    parameter logic [3:0]  NOP_ADDR  = 4'd7
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_addr,
    input  logic [15:0] cmd_data,
    output logic [1:0]  io_o,
    output logic        io_oe,
    input  logic [1:0]  io_i,
    output logic        adc_valid,
    output logic [4:0]  adc_index,
    output logic [7:0]  adc_data,
    output logic        resp_valid,
    output logic [3:0]  resp_addr,
    output logic [15:0] resp_data,
    output logic [15:0] frame_cnt
);

    localparam int unsigned FC_W   = 8;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned WORD_W = ADDR_W + DATA_W;

    localparam logic [FC_W-1:0] FC_LAST       = FC_W'(PERIOD - 1);
    localparam logic [FC_W-1:0] TX_LAST       = FC_W'(10);
    localparam logic [FC_W-1:0] TX_SHIFT_LAST = FC_W'(9);
    localparam logic [FC_W-1:0] RX_FIRST      = FC_W'(RX_OFFSET);
    localparam logic [FC_W-1:0] RX_LAST       = FC_W'(RX_OFFSET + 103);
    localparam logic [4:0]      RESP_HI_IDX   = 5'd24;

    logic [FC_W-1:0]   fc;
    logic              live;
    logic              hold_full;
    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_data;
    logic [17:0]       tx_sh;
    logic [ADDR_W-1:0] frame_addr;
    logic [5:0]        sr;
    logic [7:0]        resp_hi;

    logic              fc_wrap;
    logic [FC_W-1:0]   fc_n;
    logic              live_n;
    logic              latch;
    logic              tx_shift;
    logic [WORD_W-1:0] word_n;
    logic              accept;
    logic              hold_full_n;
    logic              rx_on;
    logic [6:0]        rx_pos;
    logic [4:0]        rx_idx;
    logic              rx_done;
    logic [7:0]        rx_byte;

    // Frame timing, command hand-off and receive window decode.
    // live stays low through the first PERIOD cycles after reset so the target can time out.
    always_comb begin
        fc_wrap     = (fc == FC_LAST);
        fc_n        = fc_wrap ? '0 : fc + FC_W'(1);
        live_n      = live | fc_wrap;
        latch       = live && (fc == '0);
        tx_shift    = live && (fc != '0) && (fc <= TX_SHIFT_LAST);
        word_n      = hold_full ? {hold_addr, hold_data} : {NOP_ADDR, 16'h0000};
        accept      = cmd_valid && cmd_ready;
        hold_full_n = hold_full;
        if (latch) begin
            hold_full_n = 1'b0;
        end
        if (accept) begin
            hold_full_n = 1'b1;
        end
        rx_on   = live && (fc >= RX_FIRST) && (fc <= RX_LAST);
        rx_pos  = 7'(fc - RX_FIRST);
        rx_idx  = rx_pos[6:2];
        rx_done = rx_on && (rx_pos[1:0] == 2'b11);
        rx_byte = {sr, io_i};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fc         <= '0;
            live       <= 1'b0;
            hold_full  <= 1'b0;
            hold_addr  <= '0;
            hold_data  <= '0;
            tx_sh      <= '0;
            frame_addr <= '0;
            sr         <= '0;
            resp_hi    <= '0;
            cmd_ready  <= 1'b1;
            io_o       <= 2'b00;
            io_oe      <= 1'b0;
            adc_valid  <= 1'b0;
            adc_index  <= '0;
            adc_data   <= '0;
            resp_valid <= 1'b0;
            resp_addr  <= '0;
            resp_data  <= '0;
            frame_cnt  <= '0;
        end else begin
            fc         <= fc_n;
            live       <= live_n;
            hold_full  <= hold_full_n;
            cmd_ready  <= !hold_full_n;
            adc_valid  <= 1'b0;
            resp_valid <= 1'b0;

            if (fc_wrap) begin
                frame_cnt <= frame_cnt + 16'd1;
            end

            if (accept) begin
                hold_addr <= cmd_addr;
                hold_data <= cmd_data;
            end

            // Outputs are registered from the next count so io_o/io_oe line up with fc.
            io_oe <= live_n && (fc_n <= TX_LAST);
            io_o  <= 2'b00;
            if (latch) begin
                io_o       <= word_n[19:18];
                tx_sh      <= word_n[17:0];
                frame_addr <= word_n[19:16];
            end else if (tx_shift) begin
                io_o  <= tx_sh[17:16];
                tx_sh <= {tx_sh[15:0], 2'b00};
            end

            if (rx_on) begin
                sr <= rx_byte[5:0];
            end
            if (rx_done) begin
                if (rx_idx < RESP_HI_IDX) begin
                    adc_valid <= 1'b1;
                    adc_index <= rx_idx;
                    adc_data  <= rx_byte;
                end else if (rx_idx == RESP_HI_IDX) begin
                    resp_hi <= rx_byte;
                end else begin
                    resp_valid <= 1'b1;
                    resp_data  <= {resp_hi, rx_byte};
                    resp_addr  <= frame_addr;
                end
            end
        end
    end

endmodule
